// File: rtl/dcache_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_responder_pkg
//  Description : Shared types, address constants and byte-merge helper for
//                the direct-mapped write-through data-cache responder.
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_responder_pkg;

    localparam int c_addr_w     = 32;
    localparam int c_data_w     = 32;
    localparam int c_be_w       = 4;
    localparam int c_byte_off_w = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL_REQ  = 3'd1,
        FILL_DATA = 3'd2,
        WR        = 3'd3,
        WR_ACK    = 3'd4
    } dcache_state_t;

    function automatic int tag_width(input int lines_log2, input int line_words_log2);
        return c_addr_w - lines_log2 - line_words_log2 - c_byte_off_w;
    endfunction

    // Lane i of the result comes from new_word when be[i] is set, else from old_word.
    function automatic logic [c_data_w-1:0] merge_bytes(
        input logic [c_data_w-1:0] old_word,
        input logic [c_data_w-1:0] new_word,
        input logic [c_be_w-1:0]   be
    );
        logic [c_data_w-1:0] v_res;
        v_res = old_word;
        for (int b = 0; b < c_be_w; b++) begin
            if (be[b]) begin
                v_res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_responder_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Valid/tag/data flop storage with a combinational read port,
//                a fill-word write port and a byte-enable store port.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_array
    import dcache_responder_pkg::*;
#(
    parameter int LINES_LOG2      = 6,
    parameter int LINE_WORDS_LOG2 = 2,
    parameter int TAG_W           = 24
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [LINES_LOG2-1:0]        i_rd_index,
    input  logic [LINE_WORDS_LOG2-1:0]   i_rd_word,
    output logic                         o_rd_valid,
    output logic [TAG_W-1:0]             o_rd_tag,
    output logic [c_data_w-1:0]          o_rd_data,
    input  logic                         i_fill_we,
    input  logic                         i_fill_last,
    input  logic [LINES_LOG2-1:0]        i_fill_index,
    input  logic [LINE_WORDS_LOG2-1:0]   i_fill_word,
    input  logic [TAG_W-1:0]             i_fill_tag,
    input  logic [c_data_w-1:0]          i_fill_data,
    input  logic                         i_st_we,
    input  logic [LINES_LOG2-1:0]        i_st_index,
    input  logic [LINE_WORDS_LOG2-1:0]   i_st_word,
    input  logic [c_data_w-1:0]          i_st_data,
    input  logic [c_be_w-1:0]            i_st_be
);

    localparam int c_lines = 1 << LINES_LOG2;
    localparam int c_words = 1 << (LINES_LOG2 + LINE_WORDS_LOG2);

    logic [c_lines-1:0]  r_valid;
    logic [TAG_W-1:0]    r_tag  [c_lines];
    logic [c_data_w-1:0] r_data [c_words];

    logic [LINES_LOG2+LINE_WORDS_LOG2-1:0] w_rd_addr;
    logic [LINES_LOG2+LINE_WORDS_LOG2-1:0] w_fill_addr;
    logic [LINES_LOG2+LINE_WORDS_LOG2-1:0] w_st_addr;

    assign w_rd_addr   = {i_rd_index, i_rd_word};
    assign w_fill_addr = {i_fill_index, i_fill_word};
    assign w_st_addr   = {i_st_index, i_st_word};

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[w_rd_addr];

    // The first fill beat drops valid so an interrupted fill never looks like a hit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
        end else if (i_fill_we) begin
            r_valid[i_fill_index] <= i_fill_last;
        end
    end

    always_ff @(posedge clock) begin
        if (i_fill_we && i_fill_last) begin
            r_tag[i_fill_index] <= i_fill_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (i_fill_we) begin
            r_data[w_fill_addr] <= i_fill_data;
        end else if (i_st_we) begin
            r_data[w_st_addr] <= merge_bytes(r_data[w_st_addr], i_st_data, i_st_be);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_responder
//  Description : Direct-mapped, write-through, no-write-allocate data cache
//                between the LS unit cache port and the memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_responder
    import dcache_responder_pkg::*;
#(
    parameter int LINES_LOG2      = 6,
    parameter int LINE_WORDS_LOG2 = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cache_rd,
    input  logic                  cache_wr,
    input  logic [c_addr_w-1:0]   cache_addr,
    input  logic [c_data_w-1:0]   cache_wr_data,
    input  logic [c_be_w-1:0]     cache_wr_be,
    output logic [c_data_w-1:0]   cache_data,
    output logic                  cache_waitrequest,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [c_addr_w-1:0]   mem_addr,
    output logic [c_data_w-1:0]   mem_wr_data,
    output logic [c_be_w-1:0]     mem_wr_be,
    input  logic [c_data_w-1:0]   mem_rd_data,
    input  logic                  mem_rd_valid,
    input  logic                  mem_waitrequest
);

    localparam int c_line_lsb = LINE_WORDS_LOG2 + c_byte_off_w;
    localparam int c_tag_lsb  = c_line_lsb + LINES_LOG2;
    localparam int c_tag_w    = tag_width(LINES_LOG2, LINE_WORDS_LOG2);

    dcache_state_t               r_state;
    logic [c_addr_w-1:0]         r_addr;
    logic [LINE_WORDS_LOG2-1:0]  r_count;
    logic                        r_mem_rd;
    logic                        r_mem_wr;
    logic [c_addr_w-1:0]         r_mem_addr;
    logic [c_data_w-1:0]         r_mem_wr_data;
    logic [c_be_w-1:0]           r_mem_wr_be;

    logic [c_addr_w-1:0]         w_lookup_addr;
    logic [LINES_LOG2-1:0]       w_index;
    logic [LINE_WORDS_LOG2-1:0]  w_word;
    logic [c_tag_w-1:0]          w_tag;
    logic                        w_arr_valid;
    logic [c_tag_w-1:0]          w_arr_tag;
    logic [c_data_w-1:0]         w_arr_data;
    logic                        w_hit;
    logic                        w_fill_we;
    logic                        w_fill_last;
    logic                        w_st_we;
    logic                        w_unused_bits;

    // Outside IDLE the requester holds its address, but the latched copy is authoritative.
    assign w_lookup_addr = (r_state == IDLE) ? cache_addr : r_addr;
    assign w_index       = w_lookup_addr[c_tag_lsb-1:c_line_lsb];
    assign w_word        = w_lookup_addr[c_line_lsb-1:c_byte_off_w];
    assign w_tag         = w_lookup_addr[c_addr_w-1:c_tag_lsb];
    assign w_hit         = w_arr_valid && (w_arr_tag == w_tag);
    assign w_unused_bits = ^w_lookup_addr[c_byte_off_w-1:0];

    assign w_fill_we   = (r_state == FILL_DATA) && mem_rd_valid;
    assign w_fill_last = &r_count;
    assign w_st_we     = (r_state == WR) && !mem_waitrequest && w_hit;

    dcache_array #(
        .LINES_LOG2      (LINES_LOG2),
        .LINE_WORDS_LOG2 (LINE_WORDS_LOG2),
        .TAG_W           (c_tag_w)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .i_rd_index   (w_index),
        .i_rd_word    (w_word),
        .o_rd_valid   (w_arr_valid),
        .o_rd_tag     (w_arr_tag),
        .o_rd_data    (w_arr_data),
        .i_fill_we    (w_fill_we),
        .i_fill_last  (w_fill_last),
        .i_fill_index (r_addr[c_tag_lsb-1:c_line_lsb]),
        .i_fill_word  (r_count),
        .i_fill_tag   (r_addr[c_addr_w-1:c_tag_lsb]),
        .i_fill_data  (mem_rd_data),
        .i_st_we      (w_st_we),
        .i_st_index   (r_addr[c_tag_lsb-1:c_line_lsb]),
        .i_st_word    (r_addr[c_line_lsb-1:c_byte_off_w]),
        .i_st_data    (r_mem_wr_data),
        .i_st_be      (r_mem_wr_be)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_count       <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_mem_wr_be   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cache_wr) begin
                        r_addr        <= cache_addr;
                        r_mem_wr      <= 1'b1;
                        r_mem_addr    <= {cache_addr[c_addr_w-1:c_byte_off_w], {c_byte_off_w{1'b0}}};
                        r_mem_wr_data <= cache_wr_data;
                        r_mem_wr_be   <= cache_wr_be;
                        r_state       <= WR;
                    end else if (cache_rd && !w_hit) begin
                        r_addr     <= cache_addr;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= {cache_addr[c_addr_w-1:c_line_lsb], {c_line_lsb{1'b0}}};
                        r_state    <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (!mem_waitrequest) begin
                        r_mem_rd <= 1'b0;
                        r_state  <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    if (mem_rd_valid) begin
                        if (w_fill_last) begin
                            r_count <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_count <= r_count + LINE_WORDS_LOG2'(1);
                        end
                    end
                end
                WR: begin
                    if (!mem_waitrequest) begin
                        r_mem_wr <= 1'b0;
                        r_state  <= WR_ACK;
                    end
                end
                WR_ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cache_waitrequest = 1'b1;
        cache_data        = '0;
        case (r_state)
            IDLE: begin
                if (cache_wr) begin
                    cache_waitrequest = 1'b1;
                end else if (cache_rd) begin
                    cache_waitrequest = !w_hit;
                end else begin
                    cache_waitrequest = 1'b0;
                end
                if (w_hit) begin
                    cache_data = w_arr_data;
                end
            end
            WR_ACK:  cache_waitrequest = 1'b0;
            default: cache_waitrequest = 1'b1;
        endcase
    end

    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wr_be   = r_mem_wr_be;

    // Simultaneous load and store is a requester protocol violation.
    always_ff @(posedge clock) begin
        if (!reset && r_state == IDLE) begin
            assert (!(cache_rd && cache_wr));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_responder
//  Description : Directed vector bench for dcache_responder with a burst
//                memory model behind the memory-side port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_responder;

    logic        clock;
    logic        reset;
    logic        cache_rd;
    logic        cache_wr;
    logic [31:0] cache_addr;
    logic [31:0] cache_wr_data;
    logic [3:0]  cache_wr_be;
    logic [31:0] cache_data;
    logic        cache_waitrequest;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_be;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_waitrequest;

    dcache_responder #(
        .LINES_LOG2      (6),
        .LINE_WORDS_LOG2 (2)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cache_rd          (cache_rd),
        .cache_wr          (cache_wr),
        .cache_addr        (cache_addr),
        .cache_wr_data     (cache_wr_data),
        .cache_wr_be       (cache_wr_be),
        .cache_data        (cache_data),
        .cache_waitrequest (cache_waitrequest),
        .mem_rd            (mem_rd),
        .mem_wr            (mem_wr),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_be         (mem_wr_be),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_valid      (mem_rd_valid),
        .mem_waitrequest   (mem_waitrequest)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory model: stall_cfg cycles of waitrequest per command, one idle
    // cycle after a read is accepted, then four consecutive beats.
    logic [31:0] backing [4096];
    int          stall_cfg = 0;
    int          rd_cmds = 0;
    int          wr_cmds = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [3:0]  last_wr_be = '0;
    int          beat_cnt = 0;
    int          beat_idx = 0;
    int          beat_delay = 0;
    int          stall = 0;
    bit          cmd_active = 0;
    logic [31:0] beat_base = '0;

    initial begin
        logic [11:0] wi;
        for (int i = 0; i < 4096; i++) backing[i] = pat(32'(i * 4));
        backing[12'h400] = 32'h11;
        backing[12'h401] = 32'h22;
        backing[12'h402] = 32'h33;
        backing[12'h403] = 32'h44;
        mem_waitrequest = 1'b1;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_rd_valid    = 1'b0;
            mem_waitrequest = 1'b1;
            if (reset) begin
                beat_cnt   = 0;
                cmd_active = 0;
            end else begin
                if (beat_cnt > 0) begin
                    if (beat_delay > 0) begin
                        beat_delay--;
                    end else begin
                        wi = beat_base[13:2] + 12'(beat_idx);
                        mem_rd_valid = 1'b1;
                        mem_rd_data  = backing[wi];
                        beat_idx++;
                        beat_cnt--;
                    end
                end
                if (mem_rd || mem_wr) begin
                    if (!cmd_active) begin
                        cmd_active = 1;
                        stall      = stall_cfg;
                    end
                    if (stall > 0) begin
                        stall--;
                    end else begin
                        mem_waitrequest = 1'b0;
                        cmd_active      = 0;
                        if (mem_rd) begin
                            rd_cmds++;
                            last_rd_addr = mem_addr;
                            beat_base    = mem_addr;
                            beat_cnt     = 4;
                            beat_idx     = 0;
                            beat_delay   = 1;
                        end else begin
                            wr_cmds++;
                            last_wr_addr = mem_addr;
                            last_wr_data = mem_wr_data;
                            last_wr_be   = mem_wr_be;
                            wi = mem_addr[13:2];
                            for (int b = 0; b < 4; b++)
                                if (mem_wr_be[b]) backing[wi][8*b +: 8] = mem_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int cyc);
        @(negedge clock);
        cache_rd   = 1'b1;
        cache_addr = a;
        #1;
        cyc = 0;
        while (cache_waitrequest && cyc <= 200) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        d = cache_data;
        @(posedge clock);
        #1;
        cache_rd = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                            output int cyc, output logic mw_seen);
        @(negedge clock);
        cache_wr      = 1'b1;
        cache_addr    = a;
        cache_wr_data = wd;
        cache_wr_be   = be;
        #1;
        cyc     = 0;
        mw_seen = 1'b0;
        while (cache_waitrequest && cyc <= 200) begin
            @(negedge clock);
            #1;
            cyc++;
            if (cyc == 1) mw_seen = mem_wr;
        end
        @(posedge clock);
        #1;
        cache_wr = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          exp_cyc;
        logic [31:0] exp_maddr;
        int          exp_cmd;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] d;
        int          cyc;
        int          base;
        int          guard;
        logic        mw_seen;

        vecs[0]  = '{0, 32'h1004, 32'h0,        4'h0, 7, 32'h1000, 1, 32'h22};
        vecs[1]  = '{0, 32'h100C, 32'h0,        4'h0, 0, 32'h0,    0, 32'h44};
        vecs[2]  = '{0, 32'h1000, 32'h0,        4'h0, 0, 32'h0,    0, 32'h11};
        vecs[3]  = '{1, 32'h1008, 32'hAABBCCDD, 4'h3, 2, 32'h1008, 1, 32'hAABBCCDD};
        vecs[4]  = '{0, 32'h1008, 32'h0,        4'h0, 0, 32'h0,    0, 32'h0000CCDD};
        vecs[5]  = '{1, 32'h2000, 32'h12345678, 4'hF, 2, 32'h2000, 1, 32'h12345678};
        vecs[6]  = '{0, 32'h2000, 32'h0,        4'h0, 7, 32'h2000, 1, 32'h12345678};
        vecs[7]  = '{0, 32'h2004, 32'h0,        4'h0, 0, 32'h0,    0, 32'hC0DE2004};
        vecs[8]  = '{0, 32'h1100, 32'h0,        4'h0, 7, 32'h1100, 1, 32'hC0DE1100};
        vecs[9]  = '{0, 32'h1404, 32'h0,        4'h0, 7, 32'h1400, 1, 32'hC0DE1404};
        vecs[10] = '{1, 32'h1404, 32'hFF000000, 4'h8, 2, 32'h1404, 1, 32'hFF000000};
        vecs[11] = '{0, 32'h1404, 32'h0,        4'h0, 0, 32'h0,    0, 32'hFFDE1404};
        vecs[12] = '{0, 32'h1008, 32'h0,        4'h0, 7, 32'h1000, 1, 32'h0000CCDD};
        vecs[13] = '{0, 32'h3FFC, 32'h0,        4'h0, 7, 32'h3FF0, 1, 32'hC0DE3FFC};

        reset         = 1'b1;
        cache_rd      = 1'b0;
        cache_wr      = 1'b0;
        cache_addr    = 32'h1004;
        cache_wr_data = '0;
        cache_wr_be   = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_waitrequest", {31'b0, cache_waitrequest}, 32'h0);
        check("reset_mem_rd",      {31'b0, mem_rd}, 32'h0);
        check("reset_mem_wr",      {31'b0, mem_wr}, 32'h0);
        check("reset_mem_addr",    mem_addr, 32'h0);
        check("reset_mem_wr_data", mem_wr_data, 32'h0);
        check("reset_mem_wr_be",   {28'b0, mem_wr_be}, 32'h0);
        check("reset_cache_data",  cache_data, 32'h0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                base = wr_cmds;
                do_write(vecs[i].addr, vecs[i].wdata, vecs[i].be, cyc, mw_seen);
                check($sformatf("v%0d_wr_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
                check($sformatf("v%0d_mem_wr_next", i), {31'b0, mw_seen}, 32'h1);
                check($sformatf("v%0d_wr_cmds", i), 32'(wr_cmds - base), 32'(vecs[i].exp_cmd));
                check($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].exp_maddr);
                check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_data);
                check($sformatf("v%0d_wr_be", i), {28'b0, last_wr_be}, {28'b0, vecs[i].be});
            end else begin
                base = rd_cmds;
                do_read(vecs[i].addr, d, cyc);
                check($sformatf("v%0d_rd_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
                check($sformatf("v%0d_rd_data", i), d, vecs[i].exp_data);
                check($sformatf("v%0d_rd_cmds", i), 32'(rd_cmds - base), 32'(vecs[i].exp_cmd));
                if (vecs[i].exp_cmd != 0)
                    check($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].exp_maddr);
            end
        end

        // Command stalled for five cycles: mem_rd and mem_addr must hold.
        stall_cfg = 5;
        base = rd_cmds;
        @(negedge clock);
        cache_rd   = 1'b1;
        cache_addr = 32'h2400;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("stall%0d_mem_rd", i), {31'b0, mem_rd}, 32'h1);
            check($sformatf("stall%0d_mem_addr", i), mem_addr, 32'h2400);
            check($sformatf("stall%0d_mem_wait", i), {31'b0, mem_waitrequest}, 32'h1);
        end
        guard = 0;
        while (cache_waitrequest && guard <= 200) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check("stall_no_timeout", 32'(guard <= 200), 32'h1);
        check("stall_rd_data", cache_data, 32'hC0DE2400);
        check("stall_rd_cmds", 32'(rd_cmds - base), 32'h1);
        @(posedge clock);
        #1;
        cache_rd  = 1'b0;
        stall_cfg = 0;

        // Reset lands on the second fill beat; the partial line must be dropped.
        base = rd_cmds;
        @(negedge clock);
        cache_rd   = 1'b1;
        cache_addr = 32'h2800;
        guard = 0;
        #1;
        while (!(mem_rd_valid && beat_idx == 2) && guard <= 100) begin
            @(negedge clock);
            #1;
            guard++;
        end
        check("rst_beat2_seen", 32'(guard <= 100), 32'h1);
        reset    = 1'b1;
        cache_rd = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_waitrequest", {31'b0, cache_waitrequest}, 32'h0);
        check("rst_mid_mem_rd", {31'b0, mem_rd}, 32'h0);
        check("rst_mid_rd_cmds", 32'(rd_cmds - base), 32'h1);
        base = rd_cmds;
        do_read(32'h2800, d, cyc);
        check("rst_reread_cycles", 32'(cyc), 32'd7);
        check("rst_reread_data", d, 32'hC0DE2800);
        check("rst_reread_cmds", 32'(rd_cmds - base), 32'h1);
        base = rd_cmds;
        do_read(32'h3FFC, d, cyc);
        check("rst_old_line_cycles", 32'(cyc), 32'd7);
        check("rst_old_line_data", d, 32'hC0DE3FFC);
        check("rst_old_line_cmds", 32'(rd_cmds - base), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
